// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 64-point streaming FFT and its
// output-side reorder buffer.
package fft_pkg;

    localparam int DATA_W = 16;
    localparam int LOG2N  = 6;
    localparam int N      = 1 << LOG2N;

    typedef enum logic {
        RD_IDLE,
        RD_READ
    } rd_state_e;

    // Mirror the low `bits` bits of `a`; bits above are returned as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] a, input int bits);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < bits; i++) begin
            r[bits-1-i] = a[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM: one write port, one registered read port, one clock.
// The address MSB selects the ping-pong bank.
module fft_reorder_ram #(
    parameter int ADDR_W = fft_pkg::LOG2N + 1,
    parameter int WORD_W = 2 * fft_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [1 << ADDR_W];
    logic [WORD_W-1:0] rd_data_q;

    // NOTE: storage and the read register are deliberately left without reset;
    // a reset term would stop the array mapping onto block RAM, and the
    // consumer gates the read data with its own valid flag.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: accepts FFT frames in bit-reversed bin order and
// re-emits each frame in natural bin order, back to back when input is.
module fft_bitrev_reorder #(
    parameter int DATA_W = fft_pkg::DATA_W,
    parameter int LOG2N  = fft_pkg::LOG2N
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_en,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_complex,
    output logic              out_en,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_complex,
    output logic [LOG2N-1:0]  out_index,
    output logic              out_first,
    output logic              out_last
);
    import fft_pkg::*;

    localparam logic [LOG2N-1:0] LAST_IDX = '1;

    logic [LOG2N-1:0]    wcnt_q, wcnt_d;
    logic [LOG2N-1:0]    rcnt_q, rcnt_d;
    logic                wbank_q, wbank_d;
    logic                rbank_q, rbank_d;
    logic [1:0]          full_q, full_d;
    rd_state_e           state_q, state_d;
    logic                out_en_q, out_en_d;
    logic                out_first_q, out_first_d;
    logic                out_last_q, out_last_d;
    logic [LOG2N-1:0]    out_index_q, out_index_d;

    logic                wr_done;
    logic                rd_issue;
    logic                other_bank;
    logic [2*DATA_W-1:0] rd_data;

    // NOTE: every signal gets a default before the case below so that no path
    // leaves one unassigned and infers a latch.
    always_comb begin
        wcnt_d      = wcnt_q;
        wbank_d     = wbank_q;
        full_d      = full_q;
        rcnt_d      = rcnt_q;
        rbank_d     = rbank_q;
        state_d     = state_q;
        rd_issue    = 1'b0;
        other_bank  = ~rbank_q;
        wr_done     = in_en && (wcnt_q == LAST_IDX);

        if (in_en) begin
            wcnt_d = wcnt_q + LOG2N'(1);
            if (wr_done) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
            end
        end

        unique case (state_q)
            RD_IDLE: begin
                if (full_q[rbank_q] || (wr_done && (wbank_q == rbank_q))) begin
                    state_d = RD_READ;
                    rcnt_d  = '0;
                end
            end
            RD_READ: begin
                rd_issue = 1'b1;
                rcnt_d   = rcnt_q + LOG2N'(1);
                if (rcnt_q == LAST_IDX) begin
                    // Writer is never on the bank being released, so this
                    // clear cannot collide with the set above.
                    full_d[rbank_q] = 1'b0;
                    rbank_d         = other_bank;
                    if (!(full_q[other_bank] || (wr_done && (wbank_q == other_bank)))) begin
                        state_d = RD_IDLE;
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase

        out_en_d    = rd_issue;
        out_index_d = rd_issue ? rcnt_q : '0;
        out_first_d = rd_issue && (rcnt_q == '0);
        out_last_d  = rd_issue && (rcnt_q == LAST_IDX);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            wbank_q     <= 1'b0;
            rbank_q     <= 1'b0;
            full_q      <= '0;
            state_q     <= RD_IDLE;
            out_en_q    <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_index_q <= '0;
        end else begin
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            wbank_q     <= wbank_d;
            rbank_q     <= rbank_d;
            full_q      <= full_d;
            state_q     <= state_d;
            out_en_q    <= out_en_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            out_index_q <= out_index_d;
        end
    end

    fft_reorder_ram #(
        .ADDR_W (LOG2N + 1),
        .WORD_W (2 * DATA_W)
    ) u_ram (
        .clock   (clock),
        .wr_en   (in_en),
        .wr_addr ({wbank_q, wcnt_q}),
        .wr_data ({in_real, in_complex}),
        .rd_en   (rd_issue),
        .rd_addr ({rbank_q, LOG2N'(bitrev(32'(rcnt_q), LOG2N))}),
        .rd_data (rd_data)
    );

    // Data is forced to zero outside valid cycles, including right after reset.
    assign out_en      = out_en_q;
    assign out_real    = out_en_q ? rd_data[2*DATA_W-1:DATA_W] : '0;
    assign out_complex = out_en_q ? rd_data[DATA_W-1:0] : '0;
    assign out_index   = out_index_q;
    assign out_first   = out_first_q;
    assign out_last    = out_last_q;

endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Output-side reorder buffer for the 64-point streaming FFT. The FFT emits each frame in bit-reversed bin order. This block accepts that stream directly from the FFT's `data_output_*` ports and re-emits every frame in natural bin order (bin 0 first). It uses a ping-pong buffer so contiguous FFT frames leave as contiguous output frames.

## Interface
- `DATA_W`, 16: width of each real and complex component.
- `LOG2N`, 6: log2 of frame length (N = 64).
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `in_en`  in  1: input sample valid; connects to FFT `data_output_en`.
- `in_real`  in  DATA_W: real part; connects to FFT `data_output_real`.
- `in_complex`  in  DATA_W: imaginary part; connects to FFT `data_output_complex`.
- `out_en`  out  1: output sample valid.
- `out_real`  out  DATA_W: real part of bin `out_index`.
- `out_complex`  out  DATA_W: imaginary part of bin `out_index`.
- `out_index`  out  LOG2N: natural-order bin number of the current output sample.
- `out_first`  out  1: high with bin 0 of each frame.
- `out_last`  out  1: high with bin N-1 of each frame.

## Operation
- Storage is two banks, each N words of 2*DATA_W bits, holding {real, complex}. Each bank has a full flag.
- **Writer.**
  - Each rising edge with `in_en`=1 writes the sample to the write bank at address `wcnt` (the arrival index), then increments `wcnt`.
  - Gaps in `in_en` are allowed. A frame is exactly N accepted samples, and `wcnt` wraps N-1 to 0.
  - On the edge that writes address N-1, the bank's full flag is set and the write bank toggles.
- **Reader FSM**, states IDLE and READ.
  - IDLE to READ: on any edge where the read bank is full, or its last sample is being written on that same edge. At that edge `rcnt`=0 is issued.
  - In READ, one read is issued per edge at address bitrev(`rcnt`), then `rcnt` increments.
  - On the edge that issues `rcnt`=N-1: clear the read bank's full flag and toggle the read bank. If the new read bank is full, or is being completed on that edge, stay in READ with `rcnt`=0 and no gap. Otherwise go to IDLE.
- Writer and reader never address the same bank at the same time. Overflow is impossible: the reader drains N samples in N cycles and the writer needs at least N cycles to fill a bank.
- Output register: `out_index` = `rcnt` of the issued read. `out_first` = (index==0). `out_last` = (index==N-1).
- Data outputs are 0 whenever `out_en`=0.
- bitrev reverses the LOG2N address bits: address bit i becomes bit LOG2N-1-i.

## Timing
- Reset values: `out_en`, `out_first`, `out_last` = 0; `out_real`, `out_complex`, `out_index` = 0.
- Reset also clears `wcnt`, `rcnt`, both full flags and both bank selects, and puts the FSM in IDLE.
- Latency: let the N-th sample of a frame be accepted at edge E. Bin k is then presented (`out_en`=1) in the cycle after edge E+1+k, for k = 0..N-1.
- Output frames are always N consecutive `out_en` cycles; output is never stalled.
- Contiguous input frames produce contiguous output frames with no idle cycle between bin N-1 and the next bin 0.
- A write of address N-1 on the same edge that the reader releases the other bank is legal; both take effect.
- Reset mid-frame: the partial input frame is discarded. Output stops immediately, with no partial frame completion after reset deasserts.
- Memory contents are not reset and are never read before being written.

## Structure
- Package `fft_pkg`: `DATA_W`, `LOG2N`, `N`, and a `bitrev` function. The FFT and its benches share this package.
- Sub-module `fft_reorder_ram`: simple dual-port RAM, 2*N x 2*DATA_W.
  - One write port and one synchronous read port, same clock.
  - Bank select is the address MSB.
- Top level holds the writer counter, full flags and reader FSM.

## Test plan
- Single frame with `in_real`=arrival index m and `in_complex`=~m, sent as 64 contiguous cycles → 64 contiguous outputs.
  - Output k carries real=bitrev(k) and `out_index`=k.
  - First output appears 2 cycles after the last input edge.
  - `out_first` is high at k=0 and `out_last` at k=63.
- Three contiguous frames with distinct values → `out_en` high for exactly 192 consecutive cycles, with each frame correctly reordered.
- Gapped input (`in_en` toggling every cycle, 128 cycles for one frame) → output is identical to the contiguous case and starts at E+2.
- Reset pulse after 30 input samples, then one full frame → exactly 64 outputs, all from the new frame.
- Reset asserted at output bin 20 → `out_en` and data are 0 in the same cycle. No further output appears until a new complete frame arrives.
- Frame with constant data 16'h7FFF/16'h8000 → passed bit-exact to the outputs, with no sign or width corruption.
